ue1_seq: RTL and testbench
==========================

UE1_SEQ -- requirements
Module: ue1_seq

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port run, input, 1, high enables sequencing; low holds the block in IDLE.
REQ-004 SHALL have ports prog_addr (output, 8, program counter) and prog_req (output, 1, fetch request).
REQ-005 SHALL have ports prog_ack (input, 1, fetch complete) and prog_data (input, 8; opcode [7:4], operand address [2:0], [3] ignored).
REQ-006 SHALL have ports core_i (output, 4, opcode), core_data (output, 1, selected input bit) and core_step (output, 1, one-cycle core clock enable).
REQ-007 SHALL have input ports core_rr, core_write, core_jmp, core_rtn and core_skip, each 1 bit, sampled from the UE-1 core.
REQ-008 SHALL have ports ext_in (input, 8, input bit bank) and ext_out (output, 8, latched output bit bank).
REQ-009 SHALL have ports halted (output, 1, RTN stop indication) and fault (output, 1, fetch timeout indication).

Function
REQ-010 SHALL implement the FSM states IDLE, FETCH, EXEC, WB and HALT.
REQ-011 IDLE: when run=1, SHALL go to FETCH on the next edge.
REQ-012 FETCH: prog_req=1 and prog_addr=pc; on an edge with prog_ack=1, SHALL latch prog_data into the instruction register and go to EXEC.
REQ-013 FETCH: prog_req SHALL drop in the cycle after ack is sampled; the minimum fetch time is 1 cycle.
REQ-014 EXEC: core_i=opcode, core_data=ext_in[operand], core_step=1 for exactly one cycle, then SHALL go to WB.
REQ-015 EXEC: if skip_pend=1, core_step SHALL stay 0, skip_pend SHALL clear, and the instruction is discarded (WB still increments pc).
REQ-016 WB: if core_write=1 and the instruction was executed, SHALL set ext_out[operand] <= core_rr; other ext_out bits unchanged.
REQ-017 WB: on core_jmp=1, SHALL set pc <= 0; otherwise pc <= pc+1, with 8-bit wrap 255->0.
REQ-018 WB: core_skip=1 SHALL set skip_pend; core_jmp=1 in the same cycle SHALL win, and skip_pend is cleared.
REQ-019 WB: core_write and core_jmp together SHALL perform both the write and the jump.
REQ-020 WB: on core_rtn=1, SHALL go to HALT after the write and pc update; otherwise FETCH if run=1, else IDLE.
REQ-021 HALT: halted=1, no fetch; SHALL go to IDLE when run=0.
REQ-022 Core outputs SHALL be ignored outside WB; core_step SHALL be 0 in all states except EXEC.
REQ-023 If run falls mid-instruction, the current instruction SHALL complete through WB before entering IDLE.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state=IDLE, pc=0, skip_pend=0, ext_out=0, instruction register=0.
REQ-025 During and after reset, until a fetch, outputs SHALL be prog_req=0, prog_addr=0, core_step=0, core_i=0, core_data=0, halted=0, fault=0.
REQ-026 Reset asserted mid-fetch SHALL drop prog_req immediately; any late prog_ack SHALL be ignored.

Configuration
REQ-027 UE1_SEQ_TIMEOUT_EN defined: an 8-bit counter SHALL count FETCH cycles; at 255 cycles without ack, the block SHALL enter HALT with fault=1.
REQ-028 UE1_SEQ_TIMEOUT_EN defined: fault SHALL clear only on reset or on the HALT->IDLE transition.
REQ-029 UE1_SEQ_TIMEOUT_EN undefined: FETCH SHALL wait indefinitely and fault SHALL be tied to 0.

Verification
REQ-030 Reset, run=1, memory acks same cycle: SHALL show prog_addr sequence 0,1,2 with 3 cycles per instruction and one core_step pulse per EXEC.
REQ-031 ext_in=8'h20, instruction 8'h15 (operand 5), core model returns write=1, rr=1: SHALL give core_data=1 in EXEC and ext_out=8'h20 after WB.
REQ-032 core_skip=1 at pc=3: SHALL fetch pc=4 with no core_step and no ext_out change; next step at pc=5.
REQ-033 core_jmp=1 and core_skip=1 at pc=255: SHALL give pc=0, skip_pend=0, and execute instruction 0.
REQ-034 core_rtn=1 at pc=7: halted=1 and no prog_req; run=0 gives IDLE; run=1 SHALL resume fetch at pc=8.
REQ-035 UE1_SEQ_TIMEOUT_EN defined, prog_ack held 0: SHALL give fault=1 and HALT after 255 FETCH cycles; undefined: prog_req stays 1 and fault stays 0.

Source files
------------

// File: rtl/ue1_seq.sv
// rtl/ue1_seq.sv - instruction fetch/execute sequencer wrapped around a UE-1 one-bit core
//
// Purpose:
//   Fetches 8-bit instructions from program memory, presents each one to an
//   external UE-1 core for a single-cycle step, then performs the write-back:
//   output bit update, program counter advance or jump, skip and return
//   handling.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   run                      1 = sequence instructions, 0 = park in IDLE
//   prog_addr, prog_req      program counter and fetch request to memory
//   prog_ack, prog_data      fetch complete and fetched instruction
//                            (opcode [7:4], operand bit address [2:0])
//   core_i, core_data        opcode and selected input bit presented in EXEC
//   core_step                one-cycle core clock enable in EXEC
//   core_rr, core_write,
//   core_jmp, core_rtn,
//   core_skip                core results, only sampled in WB
//   ext_in, ext_out          input bit bank and latched output bit bank
//   halted, fault            RTN stop indication, fetch timeout indication
//
// Build option:
//   UE1_SEQ_TIMEOUT_EN       when defined, a fetch that waits 255 cycles
//                            without acknowledge stops the block in HALT
//                            with fault=1; otherwise FETCH waits forever
//                            and fault is constant 0.

module ue1_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic [7:0] prog_addr,
    output logic       prog_req,
    input  logic       prog_ack,
    input  logic [7:0] prog_data,
    output logic [3:0] core_i,
    output logic       core_data,
    output logic       core_step,
    input  logic       core_rr,
    input  logic       core_write,
    input  logic       core_jmp,
    input  logic       core_rtn,
    input  logic       core_skip,
    input  logic [7:0] ext_in,
    output logic [7:0] ext_out,
    output logic       halted,
    output logic       fault
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WB    = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    logic [2:0] state_q,     state_d;
    logic [7:0] pc_q,        pc_d;
    logic [7:0] ir_q,        ir_d;
    logic       skip_pend_q, skip_pend_d;
    // Records whether the instruction now in WB was really stepped; a
    // skipped instruction must not let stale core results take effect.
    logic       exec_q,      exec_d;
    logic [7:0] ext_out_q,   ext_out_d;

`ifdef UE1_SEQ_TIMEOUT_EN
    logic [7:0] tmo_cnt_q,   tmo_cnt_d;
    logic       fault_q,     fault_d;
`endif

    // Bit 3 of the instruction word carries no meaning for this core.
    logic unused_ir_bit;
    assign unused_ir_bit = ir_q[3];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        skip_pend_d = skip_pend_q;
        exec_d      = exec_q;
        ext_out_d   = ext_out_q;
`ifdef UE1_SEQ_TIMEOUT_EN
        // Counter restarts from zero on every entry into FETCH.
        tmo_cnt_d   = 8'd0;
        fault_d     = fault_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (prog_ack) begin
                    ir_d    = prog_data;
                    state_d = ST_EXEC;
                end
`ifdef UE1_SEQ_TIMEOUT_EN
                // Counter holds cycles already spent waiting, so a value of
                // 254 without ack means this is the 255th FETCH cycle.
                else if (tmo_cnt_q == 8'd254) begin
                    state_d = ST_HALT;
                    fault_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end

            ST_EXEC: begin
                exec_d      = ~skip_pend_q;
                skip_pend_d = 1'b0;
                state_d     = ST_WB;
            end

            ST_WB: begin
                if (exec_q) begin
                    if (core_write) begin
                        ext_out_d[ir_q[2:0]] = core_rr;
                    end
                    // Jump beats skip: the skipped slot would belong to the
                    // instruction after the jump source, not instruction 0.
                    if (core_jmp) begin
                        pc_d        = 8'd0;
                        skip_pend_d = 1'b0;
                    end else begin
                        pc_d        = pc_q + 8'd1;
                        skip_pend_d = core_skip;
                    end
                end else begin
                    pc_d = pc_q + 8'd1;
                end

                if (exec_q && core_rtn) begin
                    state_d = ST_HALT;
                end else if (run) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_HALT: begin
                if (!run) begin
                    state_d = ST_IDLE;
`ifdef UE1_SEQ_TIMEOUT_EN
                    fault_d = 1'b0;
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= 8'd0;
            ir_q        <= 8'd0;
            skip_pend_q <= 1'b0;
            exec_q      <= 1'b0;
            ext_out_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            skip_pend_q <= skip_pend_d;
            exec_q      <= exec_d;
            ext_out_q   <= ext_out_d;
        end
    end

`ifdef UE1_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 8'd0;
            fault_q   <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            fault_q   <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    // Request is decoded straight from state so an asynchronous reset
    // withdraws it in the same instant, without waiting for a clock edge.
    assign prog_req  = (state_q == ST_FETCH);
    assign prog_addr = pc_q;

    assign core_step = (state_q == ST_EXEC) && !skip_pend_q;
    assign core_i    = (state_q == ST_EXEC) ? ir_q[7:4] : 4'd0;
    assign core_data = (state_q == ST_EXEC) ? ext_in[ir_q[2:0]] : 1'b0;

    assign ext_out = ext_out_q;
    assign halted  = (state_q == ST_HALT);

endmodule

// File: tb/tb_ue1_seq.sv
// tb/tb_ue1_seq.sv - self-checking bench for ue1_seq with instruction-level reference model

module tb_ue1_seq;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [7:0] prog_addr;
    logic       prog_req;
    logic       prog_ack;
    logic [7:0] prog_data;
    logic [3:0] core_i;
    logic       core_data;
    logic       core_step;
    logic       core_rr;
    logic       core_write;
    logic       core_jmp;
    logic       core_rtn;
    logic       core_skip;
    logic [7:0] ext_in;
    logic [7:0] ext_out;
    logic       halted;
    logic       fault;

    ue1_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .prog_addr  (prog_addr),
        .prog_req   (prog_req),
        .prog_ack   (prog_ack),
        .prog_data  (prog_data),
        .core_i     (core_i),
        .core_data  (core_data),
        .core_step  (core_step),
        .core_rr    (core_rr),
        .core_write (core_write),
        .core_jmp   (core_jmp),
        .core_rtn   (core_rtn),
        .core_skip  (core_skip),
        .ext_in     (ext_in),
        .ext_out    (ext_out),
        .halted     (halted),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural state of the program, one step per instruction.
    logic [7:0] mem [256];
    logic [7:0] m_pc;
    logic [7:0] m_ext;
    logic       m_skip;
    logic       m_halt;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one instruction from FETCH through WB. Called at a negedge with
    // the DUT expected in FETCH. The core results are presented during WB.
    task automatic do_instr(input logic w, input logic rr, input logic jmp,
                            input logic skp, input logic rtn,
                            input int ack_dly, input logic drop_run);
        logic [7:0] instr;
        logic       execd;
        chk1("fetch_req", prog_req, 1'b1);
        chk8("fetch_addr", prog_addr, m_pc);
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            chk1("fetch_wait_req", prog_req, 1'b1);
        end
        instr     = mem[m_pc];
        prog_ack  = 1'b1;
        prog_data = instr;
        tick();
        prog_ack  = 1'b0;
        prog_data = 8'($urandom);
        execd     = !m_skip;
        chk1("exec_req_drop", prog_req, 1'b0);
        chk1("exec_step", core_step, execd);
        chk8("exec_core_i", {4'd0, core_i}, {4'd0, instr[7:4]});
        chk1("exec_core_data", core_data, ext_in[instr[2:0]]);
        core_write = w;
        core_rr    = rr;
        core_jmp   = jmp;
        core_skip  = skp;
        core_rtn   = rtn;
        if (drop_run) run = 1'b0;
        tick();
        chk1("wb_step", core_step, 1'b0);
        chk1("wb_req", prog_req, 1'b0);
        tick();
        core_write = 1'b0;
        core_rr    = 1'b0;
        core_jmp   = 1'b0;
        core_skip  = 1'b0;
        core_rtn   = 1'b0;
        if (execd) begin
            if (w) m_ext[instr[2:0]] = rr;
            m_pc   = jmp ? 8'd0 : m_pc + 8'd1;
            m_skip = skp && !jmp;
            m_halt = rtn;
        end else begin
            m_pc   = m_pc + 8'd1;
            m_skip = 1'b0;
            m_halt = 1'b0;
        end
        chk8("wb_ext_out", ext_out, m_ext);
        chk1("wb_halted", halted, m_halt);
        chk1("next_req", prog_req, run && !m_halt);
        chk8("next_addr", prog_addr, m_pc);
    endtask

    initial begin
        rst_n      = 1'b0;
        run        = 1'b0;
        prog_ack   = 1'b0;
        prog_data  = 8'd0;
        ext_in     = 8'hFF;
        core_rr    = 1'b0;
        core_write = 1'b0;
        core_jmp   = 1'b0;
        core_rtn   = 1'b0;
        core_skip  = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[2] = 8'h15;
        m_pc   = 8'd0;
        m_ext  = 8'd0;
        m_skip = 1'b0;
        m_halt = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_prog_req", prog_req, 1'b0);
        chk8("rst_prog_addr", prog_addr, 8'd0);
        chk1("rst_core_step", core_step, 1'b0);
        chk8("rst_core_i", {4'd0, core_i}, 8'd0);
        chk1("rst_core_data", core_data, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk1("rst_fault", fault, 1'b0);
        chk8("rst_ext_out", ext_out, 8'd0);
        rst_n = 1'b1;
        tick();
        chk1("idle_no_req", prog_req, 1'b0);

        // Three back-to-back instructions, same-cycle ack
        run = 1'b1;
        tick();
        do_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        do_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        ext_in = 8'h20;
        do_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        chk8("write_bit5", ext_out, 8'h20);

        // Skip at pc=3; pc=4 is discarded even with every core result set
        ext_in = 8'($urandom);
        do_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        do_instr(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        chk8("skip_pc5", prog_addr, 8'd5);
        do_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        do_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Return at pc=7
        do_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        repeat (3) begin
            tick();
            chk1("halt_hold", halted, 1'b1);
            chk1("halt_no_req", prog_req, 1'b0);
        end
        run = 1'b0;
        tick();
        chk1("halt_to_idle", halted, 1'b0);
        chk1("idle_req", prog_req, 1'b0);
        run    = 1'b1;
        m_halt = 1'b0;
        tick();
        chk1("resume_req", prog_req, 1'b1);
        chk8("resume_addr", prog_addr, 8'd8);

        // Random program up to pc=255
        while (m_pc != 8'd255) begin
            ext_in = 8'($urandom);
            do_instr(1'($urandom), 1'($urandom), 1'b0,
                     (m_pc != 8'd254) && ($urandom_range(0, 3) == 0), 1'b0,
                     int'($urandom_range(0, 3)), 1'b0);
        end

        // Jump and skip together at pc=255
        do_instr(1'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b0, 0, 1'b0);
        chk8("jmp_wrap_pc", prog_addr, 8'd0);
        ext_in = 8'($urandom);
        // Instruction 0 must execute; run drops mid-instruction
        do_instr(1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 0, 1'b1);
        tick();
        chk1("run_drop_idle", prog_req, 1'b0);
        run = 1'b1;
        tick();
        chk1("run_restart_req", prog_req, 1'b1);
        chk8("run_restart_addr", prog_addr, 8'd1);

        // Reset during FETCH, with a late ack while in reset
        rst_n = 1'b0;
        #1;
        chk1("rst_mid_fetch_req", prog_req, 1'b0);
        prog_ack = 1'b1;
        tick();
        prog_ack = 1'b0;
        chk1("rst_late_ack_req", prog_req, 1'b0);
        chk8("rst_late_ack_addr", prog_addr, 8'd0);
        chk8("rst_late_ack_ext", ext_out, 8'd0);
        chk1("rst_late_ack_step", core_step, 1'b0);
        rst_n  = 1'b1;
        m_pc   = 8'd0;
        m_ext  = 8'd0;
        m_skip = 1'b0;
        tick();

        // Fetch never acknowledged
        chk1("tmo_first_req", prog_req, 1'b1);
        repeat (254) @(posedge clk);
        @(negedge clk);
        chk1("tmo_255_req", prog_req, 1'b1);
        chk1("tmo_255_fault", fault, 1'b0);
        tick();
`ifdef UE1_SEQ_TIMEOUT_EN
        chk1("tmo_halted", halted, 1'b1);
        chk1("tmo_fault", fault, 1'b1);
        chk1("tmo_no_req", prog_req, 1'b0);
        run = 1'b0;
        tick();
        chk1("tmo_fault_clear", fault, 1'b0);
        chk1("tmo_idle", halted, 1'b0);
`else
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk1("wait_req", prog_req, 1'b1);
        chk1("wait_fault", fault, 1'b0);
        chk1("wait_halted", halted, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
